// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control unit: sequences IF/ID/EXE/MEM/WB and retires instructions.
// Outputs are combinational from state/Opcode/flags, one state per CLK; no backpressure.
module multicycle_control_unit (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [5:0]  Opcode,
    input  logic        zero,
    input  logic        sign,
    output logic [2:0]  state,
    output logic        PCWre,
    output logic        IRWre,
    output logic        RegWre,
    output logic        mRD,
    output logic        mWR,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        ExtSel,
    output logic        DBDataSrc,
    output logic        WrRegDSrc,
    output logic [1:0]  RegDst,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ALUOp,
    output logic [31:0] icount
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_e      state_q, state_d;
    logic        fetch_armed_q;
    logic [31:0] icount_q, icount_d;

    logic is_add, is_sub, is_addi, is_or, is_and, is_ori, is_sll, is_slt, is_sltiu;
    logic is_sw, is_lw, is_beq, is_bltz, is_j, is_jr, is_jal, is_halt;
    logic is_alu, is_br, is_ls, is_jmp, is_illegal;
    logic pc_final;

    assign is_add   = (Opcode == OP_ADD);
    assign is_sub   = (Opcode == OP_SUB);
    assign is_addi  = (Opcode == OP_ADDI);
    assign is_or    = (Opcode == OP_OR);
    assign is_and   = (Opcode == OP_AND);
    assign is_ori   = (Opcode == OP_ORI);
    assign is_sll   = (Opcode == OP_SLL);
    assign is_slt   = (Opcode == OP_SLT);
    assign is_sltiu = (Opcode == OP_SLTIU);
    assign is_sw    = (Opcode == OP_SW);
    assign is_lw    = (Opcode == OP_LW);
    assign is_beq   = (Opcode == OP_BEQ);
    assign is_bltz  = (Opcode == OP_BLTZ);
    assign is_j     = (Opcode == OP_J);
    assign is_jr    = (Opcode == OP_JR);
    assign is_jal   = (Opcode == OP_JAL);
    assign is_halt  = (Opcode == OP_HALT);

    assign is_alu     = is_add | is_sub | is_addi | is_or | is_and | is_ori | is_sll | is_slt | is_sltiu;
    assign is_br      = is_beq | is_bltz;
    assign is_ls      = is_lw | is_sw;
    assign is_jmp     = is_j | is_jr | is_jal;
    assign is_illegal = ~(is_alu | is_br | is_ls | is_jmp | is_halt);

    always_comb begin
        state_d = state_q;
        case (state_q)
            // The first edge after reset only loads the IR; fetch advances from the second edge on.
            S_IF:     state_d = fetch_armed_q ? S_ID : S_IF;
            S_ID: begin
                if (is_alu)       state_d = S_EXE_AL;
                else if (is_br)   state_d = S_EXE_BR;
                else if (is_ls)   state_d = S_EXE_LS;
                else if (is_halt) state_d = S_ID;
                else              state_d = S_IF;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    assign pc_final = (state_q == S_WB_AL) || (state_q == S_EXE_BR) || (state_q == S_WB_LD)
                   || ((state_q == S_MEM) && is_sw)
                   || ((state_q == S_ID) && (is_jmp || is_illegal));

    always_comb begin
        PCWre  = Reset & pc_final;
        IRWre  = Reset & (state_q == S_IF);
        RegWre = Reset & ((state_q == S_WB_AL) || (state_q == S_WB_LD) || ((state_q == S_ID) && is_jal));
        mRD    = Reset & (state_q == S_MEM) & is_lw;
        mWR    = Reset & (state_q == S_MEM) & is_sw;

        ALUSrcA   = is_sll;
        ALUSrcB   = is_addi | is_ori | is_sltiu | is_lw | is_sw;
        ExtSel    = ~(is_ori | is_sltiu);
        DBDataSrc = is_lw;
        WrRegDSrc = ~is_jal;

        RegDst = 2'b10;
        if (is_jal)                                    RegDst = 2'b00;
        else if (is_addi || is_ori || is_sltiu || is_lw) RegDst = 2'b01;

        ALUOp = 3'b000;
        if (is_sub || is_br)     ALUOp = 3'b001;
        else if (is_or || is_ori) ALUOp = 3'b011;
        else if (is_and)          ALUOp = 3'b100;
        else if (is_sll)          ALUOp = 3'b010;
        else if (is_slt)          ALUOp = 3'b110;
        else if (is_sltiu)        ALUOp = 3'b101;

        PCSrc = 2'b00;
        if (state_q == S_EXE_BR) begin
            if ((is_beq && zero) || (is_bltz && sign)) PCSrc = 2'b01;
        end else if (state_q == S_ID) begin
            if (is_j || is_jal) PCSrc = 2'b11;
            else if (is_jr)     PCSrc = 2'b10;
        end
    end

    assign icount_d = PCWre ? icount_q + 32'd1 : icount_q;
    assign state    = state_q;
    assign icount   = icount_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_IF;
            fetch_armed_q <= 1'b0;
            icount_q      <= 32'd0;
        end else begin
            state_q       <= state_d;
            fetch_armed_q <= 1'b1;
            icount_q      <= icount_d;
        end
    end

endmodule
